prom_programmer: RTL
====================

// Module: prom_programmer
// PURPOSE
//  Programmable counterpart of the fixed decoder + OR-plane PROM function block: the write/program side.
//  Loads a DEPTH x OUT_W OR-plane serially, verifies it against a host XOR checksum, then serves registered lookups.
//  Sits between a host/programming bench and logic consuming F; the read side mirrors the fixed PROM (A, en -> F).
// PARAMETERS
//  ADDR_W  2  address width; DEPTH = 2**ADDR_W words
//  OUT_W   2  output functions per word (F[0] = F1, F[1] = F2, ...)
// PORTS
//  clk         in   1              rising-edge clock, the only clock
//  rst         in   1              synchronous, active-high reset
//  prog_start  in   1              pulse: begin (or restart) programming
//  prog_valid  in   1              prog_bit is valid this cycle (LOAD only)
//  prog_bit    in   1              serial program data, word 0 first, LSB first
//  chk_in      in   OUT_W          expected XOR of all words; sampled at VERIFY end
//  A           in   ADDR_W         lookup address
//  en          in   1              lookup enable (decoder enable)
//  F           out  OUT_W          registered lookup result
//  busy        out  1              1 in LOAD or VERIFY
//  ready       out  1              1 in READY (contents verified)
//  err         out  1              sticky checksum-fail flag
// BEHAVIOUR
//  Reset: state=IDLE; all mem words=0; bit/word counters=0; F=0, busy=0, ready=0, err=0.
//  FSM states: IDLE, LOAD, VERIFY, READY. Registered state; outputs decoded from registered state.
//  IDLE:   prog_start -> LOAD (counters=0, err<=0). prog_valid ignored.
//  LOAD:   each prog_valid cycle writes prog_bit to mem[word_cnt][bit_cnt]; bit_cnt++;
//          bit_cnt wraps at OUT_W-1 -> 0 with word_cnt++. On write of the final bit
//          (word DEPTH-1, bit OUT_W-1) -> VERIFY next cycle, word_cnt=0, acc=0.
//          Cycles without prog_valid hold counters; no timeout.
//  VERIFY: one word per cycle: acc <= acc ^ mem[word_cnt]; DEPTH cycles total.
//          On the cycle after the last word: acc==chk_in -> READY; else err<=1 -> IDLE.
//          chk_in must be stable during that compare cycle.
//  READY:  F <= en ? mem[A] : 0 every cycle; latency 1 clk from A/en to F.
//          prog_start -> LOAD (mem is overwritten bit by bit; ready drops next cycle).
//  Outside READY, F is driven 0 (registered: F=0 from the first cycle after leaving READY).
//  prog_start in LOAD or VERIFY: restart LOAD, counters=0, acc=0, err<=0; mem not cleared.
//  prog_start and prog_valid same cycle in IDLE/READY: start wins, bit discarded.
//  prog_start and final-bit prog_valid same cycle in LOAD: start wins, bit discarded.
//  err stays 1 until next prog_start or rst. ready and err never both 1.
//  rst mid-LOAD/VERIFY/READY: full reset as above in the same cycle, mem cleared.
//  Widths: word_cnt ADDR_W bits, bit_cnt $clog2(OUT_W) bits (min 1), acc OUT_W bits.
//  Program time: DEPTH*OUT_W valid beats + DEPTH+1 verify cycles; default 8 + 5.
// TESTING
//  1 rst asserted 2 clks -> F=0, busy=0, ready=0, err=0; all A with en=1 read 0.
//  2 Program F1=m(1,2), F2=m(0,1,3): prog_start, bits 0,1,1,1,1,0,0,1 back-to-back,
//    chk_in=2'b10 -> busy 13 clks, ready=1; reads A=0..3, en=1 -> F=10,11,01,10 one clk later.
//  3 Same program, chk_in=2'b01 -> err=1, ready=0, state IDLE, F=0 for any A/en.
//  4 In READY, en=0 for A=1 -> F=00; toggle en each clk -> F follows with 1-clk lag.
//  5 prog_start after 3 bits of LOAD, then full 8-bit stream of all 1s, chk_in=2'b00
//    -> ready=1, every read returns 11 (restart discards partial progress).
//  6 rst during VERIFY -> next clk busy=0, ready=0; after reprogramming with zeros and
//    chk_in=00, all reads return 00 (mem cleared, no stale data).

Source files
------------

// File: rtl/prom_programmer.sv
// prom_programmer: serial loader for a DEPTH x OUT_W OR-plane.
// Loads the plane bit by bit, checks it against a host XOR checksum,
// then serves registered lookups (A, en -> F) like the fixed PROM.
module prom_programmer #(
    parameter int ADDR_W = 2,
    parameter int OUT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic              prog_bit,
    input  logic [OUT_W-1:0]  chk_in,
    input  logic [ADDR_W-1:0] A,
    input  logic              en,
    output logic [OUT_W-1:0]  F,
    output logic              busy,
    output logic              ready,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int          BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] VERIFY = 2'd2;
    localparam logic [1:0] READY  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] word_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [OUT_W-1:0]  acc;
    logic              verify_done;
    logic [OUT_W-1:0]  mem [DEPTH];

    // Programming FSM: load, checksum walk, compare; prog_start overrides any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            acc         <= '0;
            verify_done <= 1'b0;
            err         <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (prog_start) begin
            state       <= LOAD;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            acc         <= '0;
            verify_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (prog_valid) begin
                        mem[word_cnt][bit_cnt] <= prog_bit;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt  <= '0;
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt == WORD_LAST) begin
                                state       <= VERIFY;
                                word_cnt    <= '0;
                                acc         <= '0;
                                verify_done <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    // DEPTH accumulate cycles, then one compare cycle
                    if (!verify_done) begin
                        acc      <= acc ^ mem[word_cnt];
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == WORD_LAST) begin
                            verify_done <= 1'b1;
                        end
                    end else begin
                        word_cnt    <= '0;
                        verify_done <= 1'b0;
                        if (acc == chk_in) begin
                            state <= READY;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered lookup; a start in READY zeroes F as the FSM leaves READY
    always_ff @(posedge clk) begin
        if (rst) begin
            F <= '0;
        end else if (state == READY && !prog_start && en) begin
            F <= mem[A];
        end else begin
            F <= '0;
        end
    end

    assign busy  = (state == LOAD) || (state == VERIFY);
    assign ready = (state == READY);

endmodule
